// File: rtl/cla_pkg.sv
// Shared sizing constants for the 32-bit carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned CLA_GRP   = 4;
  localparam int unsigned CLA_NGRP  = CLA_WIDTH / CLA_GRP;

endpackage : cla_pkg

// File: rtl/cla_4.sv
// 4-bit carry-lookahead group: full lookahead internal carries from cin,
// plus group propagate/generate for the second-level carry unit.
module cla_4
  import cla_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               cin,
  output logic [CLA_GRP-1:0] s,
  output logic               pg,
  output logic               gg
);

  logic [CLA_GRP-1:0] g;
  logic [CLA_GRP-1:0] p;
  logic [CLA_GRP-1:0] c;

  // Per-bit generate/propagate, flattened carries, sum and group terms.
  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);

    s  = p ^ c;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule : cla_4

// File: rtl/cla_32.sv
// 32-bit two-level carry-lookahead adder with registered sum, carry-out and
// signed-overflow flag. One-cycle latency, one operation per cycle.
module cla_32
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 c_in,
  output logic [CLA_WIDTH-1:0] s,
  output logic                 c_out,
  output logic                 overflow
);

  logic [CLA_NGRP-1:0]  grp_p;
  logic [CLA_NGRP-1:0]  grp_g;
  logic [CLA_NGRP:0]    grp_c;
  logic [CLA_WIDTH-1:0] sum;
  logic                 c31;

  logic [CLA_WIDTH-1:0] s_d,   s_q;
  logic                 c_out_d, c_out_q;
  logic                 ovf_d,   ovf_q;

  for (genvar k = 0; k < CLA_NGRP; k++) begin : g_grp
    cla_4 u_cla_4 (
      .a   (a[k*CLA_GRP +: CLA_GRP]),
      .b   (b[k*CLA_GRP +: CLA_GRP]),
      .cin (grp_c[k]),
      .s   (sum[k*CLA_GRP +: CLA_GRP]),
      .pg  (grp_p[k]),
      .gg  (grp_g[k])
    );
  end : g_grp

  // Second-level lookahead: each group carry is an independent sum of products.
  always_comb begin
    logic acc;
    logic term;
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int unsigned k = 0; k < CLA_NGRP; k++) begin
      acc = c_in;
      for (int unsigned j = 0; j <= k; j++) begin
        acc = acc & grp_p[j];
      end
      for (int unsigned j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int unsigned m = j + 1; m <= k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end
  end

  // Carry into bit 31 recovered from the sum bit; next-state for the output register.
  always_comb begin
    c31     = sum[CLA_WIDTH-1] ^ a[CLA_WIDTH-1] ^ b[CLA_WIDTH-1];
    s_d     = sum;
    c_out_d = grp_c[CLA_NGRP];
    ovf_d   = c31 ^ grp_c[CLA_NGRP];
  end

  // Output register; synchronous reset has priority over loading a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s        = s_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule : cla_32

// File: tb/tb_cla_32.sv
// Directed and randomised self-checking bench for cla_32.
module tb_cla_32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;
  logic        overflow;

  int unsigned n_checks;
  int unsigned n_errors;

  cla_32 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .s        (s),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {c_out, overflow, s} against an expected triple.
  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got c_out=%0b ovf=%0b s=%08h, expected c_out=%0b ovf=%0b s=%08h",
               tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Apply one operation, clock it in, and check the registered result.
  task automatic op(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                    input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    a    = ai;
    b    = bi;
    c_in = ci;
    @(posedge clk);
    #1;
    check(tag, {c_out, overflow, s}, {ec, eo, es});
  endtask

  initial begin
    logic [32:0] wide;
    logic [31:0] one;
    logic [31:0] ra, rb;
    logic        rc;
    logic [31:0] es;
    logic        ec, eo;

    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    a    = 32'hDEADBEEF;
    b    = 32'h12345678;
    c_in = 1'b1;

    // Reset held two cycles with arbitrary operands.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", {c_out, overflow, s}, 34'h0);
      a = a + 32'h1111;
    end
    rst = 1'b0;

    // Group boundary vectors.
    for (int k = 0; k < 8; k++) begin
      one = 32'h1 << (4 * k);
      op($sformatf("grp%0d_a", k), one, 32'h0, 1'b0, one, 1'b0, 1'b0);
      op($sformatf("grp%0d_b", k), 32'h0, one, 1'b0, one, 1'b0, 1'b0);
      one = 32'h1 << (4 * k + 3);
      if (k == 7) begin
        op("grp7_cross", one, one, 1'b0, 32'h0, 1'b1, 1'b1);
      end else begin
        op($sformatf("grp%0d_cross", k), one, one, 1'b0, 32'h1 << (4 * k + 4), 1'b0, 1'b0);
      end
    end

    op("cin_only",    32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    op("min_min",     32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    op("ones_cin",    32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    op("max_plus1",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op("ones_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    op("alt_pattern", 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0);
    op("neg_ovf",     32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Back-to-back random operations with a reset pulse in the middle.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i == 5000) begin
        rst = 1'b1;
        op("mid_reset", ra, rb, rc, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        wide = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
        es   = wide[31:0];
        ec   = wide[32];
        eo   = (ra[31] == rb[31]) && (es[31] != ra[31]);
        op("random", ra, rb, rc, es, ec, eo);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cla_32
